// File: rtl/decode_stage_if.sv
// rv32i control-field types plus the fetch/execute bundle interface of the decode stage.
// slave = decode stage side, master = the fetch/execute environment driving it.
package rv32i_pkg;
  typedef enum logic [4:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_JAL, ALU_JALR, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
    ALU_BGEU, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM,
    ALU_REMU
  } alu_op_e;
  typedef enum logic [1:0] {ALU_INPUT_NONE, ALU_INPUT_REG, ALU_INPUT_IMM, ALU_INPUT_PC} alu_input_type_e;
  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_PC} wb_from_e;
  typedef enum logic {REG_WD, REG_WE} reg_we_e;
  typedef enum logic {MEM_LOAD, MEM_STORE} mem_op_e;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv32i_r_t;

  typedef union packed {
    logic [31:0] raw;
    rv32i_r_t    r;
  } rv32i_inst_u;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
endpackage

interface decode_stage_if #(parameter int XLEN = 32);
  import rv32i_pkg::*;

  logic            in_valid;
  logic            in_ready;
  rv32i_inst_u     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  alu_op_e         out_alu_op;
  alu_input_type_e out_alu_in1;
  alu_input_type_e out_alu_in2;
  wb_from_e        out_wb_from;
  reg_we_e         out_r_we;
  mem_op_e         out_mem_op;
  logic [2:0]      out_funct3;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_op,
           out_alu_in1, out_alu_in2, out_wb_from, out_r_we, out_mem_op, out_funct3, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_op,
           out_alu_in1, out_alu_in2, out_wb_from, out_r_we, out_mem_op, out_funct3, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: 1-cycle accept->valid latency, 1 instr/cycle throughput.
// Backpressure absorbed by a 2-entry output+skid buffer; in_ready depends only on state.
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  decode_stage_if.slave    bus,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    alu_op_e         alu_op;
    alu_input_type_e alu_in1;
    alu_input_type_e alu_in2;
    wb_from_e        wb_from;
    reg_we_e         r_we;
    mem_op_e         mem_op;
    logic [2:0]      funct3;
    logic            illegal;
  } bundle_t;

  localparam bundle_t NOP_BUNDLE = '{
    pc: '0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: '0, alu_op: ALU_NOP,
    alu_in1: ALU_INPUT_NONE, alu_in2: ALU_INPUT_NONE, wb_from: WB_NONE,
    r_we: REG_WD, mem_op: MEM_LOAD, funct3: 3'd0, illegal: 1'b0
  };

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  state_e           state_q, state_d;
  bundle_t          out_q, out_d;
  bundle_t          skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  rv32i_inst_u ins;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  bundle_t     dec_raw, dec;
  logic        dec_ill;
  logic        accept, xfer;

  assign ins   = bus.in_instr;
  assign imm_i = {{20{ins.raw[31]}}, ins.raw[31:20]};
  assign imm_s = {{20{ins.raw[31]}}, ins.raw[31:25], ins.raw[11:7]};
  assign imm_b = {{19{ins.raw[31]}}, ins.raw[31], ins.raw[7], ins.raw[30:25], ins.raw[11:8], 1'b0};
  assign imm_u = {ins.raw[31:12], 12'b0};
  assign imm_j = {{11{ins.raw[31]}}, ins.raw[31], ins.raw[19:12], ins.raw[20], ins.raw[30:21], 1'b0};

  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_e m_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

  always_comb begin
    dec_raw        = NOP_BUNDLE;
    dec_raw.pc     = bus.in_pc;
    dec_raw.funct3 = ins.r.funct3;
    dec_ill        = 1'b0;
    if (ins.r.opcode[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end else begin
      case (ins.r.opcode)
        OPC_LUI: begin
          dec_raw.rd = ins.r.rd; dec_raw.imm = imm_u; dec_raw.alu_op = ALU_ADD;
          dec_raw.alu_in1 = ALU_INPUT_IMM; dec_raw.wb_from = WB_ALU; dec_raw.r_we = REG_WE;
        end
        OPC_AUIPC: begin
          dec_raw.rd = ins.r.rd; dec_raw.imm = imm_u; dec_raw.alu_op = ALU_ADD;
          dec_raw.alu_in1 = ALU_INPUT_PC; dec_raw.alu_in2 = ALU_INPUT_IMM;
          dec_raw.wb_from = WB_ALU; dec_raw.r_we = REG_WE;
        end
        OPC_JAL: begin
          dec_raw.rd = ins.r.rd; dec_raw.imm = imm_j; dec_raw.alu_op = ALU_JAL;
          dec_raw.alu_in1 = ALU_INPUT_PC; dec_raw.alu_in2 = ALU_INPUT_IMM;
          dec_raw.wb_from = WB_PC; dec_raw.r_we = REG_WE;
        end
        OPC_JALR: begin
          dec_raw.rd = ins.r.rd; dec_raw.rs1 = ins.r.rs1; dec_raw.imm = imm_i;
          dec_raw.alu_op = ALU_JALR; dec_raw.alu_in1 = ALU_INPUT_REG;
          dec_raw.alu_in2 = ALU_INPUT_IMM; dec_raw.wb_from = WB_PC; dec_raw.r_we = REG_WE;
          dec_ill = (ins.r.funct3 != 3'b000);
        end
        OPC_BRANCH: begin
          dec_raw.rs1 = ins.r.rs1; dec_raw.rs2 = ins.r.rs2; dec_raw.imm = imm_b;
          dec_raw.alu_in1 = ALU_INPUT_REG; dec_raw.alu_in2 = ALU_INPUT_REG;
          case (ins.r.funct3)
            3'b000:  dec_raw.alu_op = ALU_BEQ;
            3'b001:  dec_raw.alu_op = ALU_BNE;
            3'b100:  dec_raw.alu_op = ALU_BLT;
            3'b101:  dec_raw.alu_op = ALU_BGE;
            3'b110:  dec_raw.alu_op = ALU_BLTU;
            3'b111:  dec_raw.alu_op = ALU_BGEU;
            default: dec_ill = 1'b1;
          endcase
        end
        OPC_LOAD: begin
          dec_raw.rd = ins.r.rd; dec_raw.rs1 = ins.r.rs1; dec_raw.imm = imm_i;
          dec_raw.alu_op = ALU_ADD; dec_raw.alu_in1 = ALU_INPUT_REG;
          dec_raw.alu_in2 = ALU_INPUT_IMM; dec_raw.wb_from = WB_MEM; dec_raw.r_we = REG_WE;
          dec_ill = (ins.r.funct3 == 3'b011) || (ins.r.funct3 == 3'b110) || (ins.r.funct3 == 3'b111);
        end
        OPC_STORE: begin
          dec_raw.rs1 = ins.r.rs1; dec_raw.rs2 = ins.r.rs2; dec_raw.imm = imm_s;
          dec_raw.alu_op = ALU_ADD; dec_raw.alu_in1 = ALU_INPUT_REG;
          dec_raw.alu_in2 = ALU_INPUT_IMM; dec_raw.mem_op = MEM_STORE;
          dec_ill = (ins.r.funct3 >= 3'b011);
        end
        OPC_OPIMM: begin
          dec_raw.rd = ins.r.rd; dec_raw.rs1 = ins.r.rs1; dec_raw.imm = imm_i;
          dec_raw.alu_op = base_op(ins.r.funct3); dec_raw.alu_in1 = ALU_INPUT_REG;
          dec_raw.alu_in2 = ALU_INPUT_IMM; dec_raw.wb_from = WB_ALU; dec_raw.r_we = REG_WE;
          // Shift-immediates reuse funct7 as the upper imm bits.
          if (ins.r.funct3 == 3'b001) begin
            dec_ill = (ins.r.funct7 != 7'b0000000);
          end else if (ins.r.funct3 == 3'b101) begin
            if (ins.r.funct7 == 7'b0100000) dec_raw.alu_op = ALU_SRA;
            else if (ins.r.funct7 != 7'b0000000) dec_ill = 1'b1;
          end
        end
        OPC_OP: begin
          dec_raw.rd = ins.r.rd; dec_raw.rs1 = ins.r.rs1; dec_raw.rs2 = ins.r.rs2;
          dec_raw.alu_in1 = ALU_INPUT_REG; dec_raw.alu_in2 = ALU_INPUT_REG;
          dec_raw.wb_from = WB_ALU; dec_raw.r_we = REG_WE;
          case (ins.r.funct7)
            7'b0000000: dec_raw.alu_op = base_op(ins.r.funct3);
            7'b0100000: begin
              if (ins.r.funct3 == 3'b000)      dec_raw.alu_op = ALU_SUB;
              else if (ins.r.funct3 == 3'b101) dec_raw.alu_op = ALU_SRA;
              else                             dec_ill = 1'b1;
            end
            7'b0000001: begin
              if (ENABLE_M) dec_raw.alu_op = m_op(ins.r.funct3);
              else          dec_ill = 1'b1;
            end
            default: dec_ill = 1'b1;
          endcase
        end
        OPC_FENCE, OPC_SYSTEM: ;
        default: dec_ill = 1'b1;
      endcase
    end
    if (dec_raw.rd == 5'd0) dec_raw.r_we = REG_WD;
  end

  always_comb begin
    dec = dec_raw;
    if (dec_ill) begin
      dec         = NOP_BUNDLE;
      dec.pc      = bus.in_pc;
      dec.illegal = 1'b1;
    end
  end

  assign bus.in_ready  = (state_q != S_TWO);
  assign bus.out_valid = (state_q != S_EMPTY);
  assign accept        = bus.in_valid & bus.in_ready;
  assign xfer          = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      if (accept && dec.illegal && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            out_d   = dec;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && xfer) begin
            out_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = S_TWO;
          end else if (xfer) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (xfer) begin
            out_d   = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      out_q   <= NOP_BUNDLE;
      skid_q  <= NOP_BUNDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_pc      = out_q.pc;
  assign bus.out_rs1     = out_q.rs1;
  assign bus.out_rs2     = out_q.rs2;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_alu_op  = out_q.alu_op;
  assign bus.out_alu_in1 = out_q.alu_in1;
  assign bus.out_alu_in2 = out_q.alu_in2;
  assign bus.out_wb_from = out_q.wb_from;
  assign bus.out_r_we    = out_q.r_we;
  assign bus.out_mem_op  = out_q.mem_op;
  assign bus.out_funct3  = out_q.funct3;
  assign bus.out_illegal = out_q.illegal;
  assign illegal_cnt     = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one base-ISA instance (CNT_W=16) and one RV32M
// instance with a 2-bit counter to reach saturation.
module tb_decode_stage;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        flush_m = 1'b0;
  logic [15:0] cnt;
  logic [1:0]  cnt_m;
  int          n_chk = 0;
  int          n_err = 0;

  decode_stage_if #(.XLEN(32)) dif ();
  decode_stage_if #(.XLEN(32)) dif_m ();

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(dif.slave), .illegal_cnt(cnt)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .CNT_W(2)) u_dut_m (
    .clk(clk), .reset(reset), .flush(flush_m), .bus(dif_m.slave), .illegal_cnt(cnt_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] ins, input logic [31:0] pc);
    dif.in_valid = 1'b1;
    dif.in_instr = ins;
    dif.in_pc    = pc;
  endtask

  task automatic put_m(input logic [31:0] ins, input logic [31:0] pc);
    dif_m.in_valid = 1'b1;
    dif_m.in_instr = ins;
    dif_m.in_pc    = pc;
  endtask

  initial begin
    dif.in_valid = 1'b0; dif.in_instr = '0; dif.in_pc = '0; dif.out_ready = 1'b0;
    dif_m.in_valid = 1'b0; dif_m.in_instr = '0; dif_m.in_pc = '0; dif_m.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
    chk("rst_in_ready", 32'(dif.in_ready), 32'd1);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_alu_op", 32'(dif.out_alu_op), 32'(ALU_NOP));
    chk("rst_r_we", 32'(dif.out_r_we), 32'(REG_WD));
    chk("rst_in1", 32'(dif.out_alu_in1), 32'(ALU_INPUT_NONE));
    reset = 1'b0;
    tick();

    // ADDI, LUI, SW back-to-back with execute always ready
    dif.out_ready = 1'b1;
    put(32'h00500093, 32'h0);
    tick();
    chk("addi_valid", 32'(dif.out_valid), 32'd1);
    chk("addi_rd", 32'(dif.out_rd), 32'd1);
    chk("addi_rs1", 32'(dif.out_rs1), 32'd0);
    chk("addi_imm", dif.out_imm, 32'd5);
    chk("addi_op", 32'(dif.out_alu_op), 32'(ALU_ADD));
    chk("addi_in2", 32'(dif.out_alu_in2), 32'(ALU_INPUT_IMM));
    chk("addi_we", 32'(dif.out_r_we), 32'(REG_WE));
    chk("addi_ill", 32'(dif.out_illegal), 32'd0);
    put(32'h123450B7, 32'h4);
    tick();
    chk("lui_imm", dif.out_imm, 32'h12345000);
    chk("lui_pc", dif.out_pc, 32'h4);
    chk("lui_in1", 32'(dif.out_alu_in1), 32'(ALU_INPUT_IMM));
    chk("lui_in2", 32'(dif.out_alu_in2), 32'(ALU_INPUT_NONE));
    put(32'h0020A423, 32'h8);
    tick();
    chk("sw_imm", dif.out_imm, 32'd8);
    chk("sw_mem", 32'(dif.out_mem_op), 32'(MEM_STORE));
    chk("sw_we", 32'(dif.out_r_we), 32'(REG_WD));
    chk("sw_rs1", 32'(dif.out_rs1), 32'd1);
    chk("sw_rs2", 32'(dif.out_rs2), 32'd2);
    chk("sw_f3", 32'(dif.out_funct3), 32'd2);
    dif.in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(dif.out_valid), 32'd0);

    // Backpressure: three offered, two held, then in-order release
    dif.out_ready = 1'b0;
    put(32'h00100093, 32'h100);
    tick();
    chk("bp1_in_ready", 32'(dif.in_ready), 32'd1);
    put(32'h00200113, 32'h104);
    tick();
    chk("bp2_in_ready", 32'(dif.in_ready), 32'd0);
    put(32'h00300193, 32'h108);
    tick();
    chk("bp3_held_ready", 32'(dif.in_ready), 32'd0);
    chk("bp3_out_pc", dif.out_pc, 32'h100);
    dif.out_ready = 1'b1;
    tick();
    chk("bp4_out_pc", dif.out_pc, 32'h104);
    chk("bp4_imm", dif.out_imm, 32'd2);
    chk("bp4_in_ready", 32'(dif.in_ready), 32'd1);
    tick();
    chk("bp5_out_pc", dif.out_pc, 32'h108);
    chk("bp5_rd", 32'(dif.out_rd), 32'd3);
    dif.in_valid = 1'b0;
    tick();
    chk("bp6_valid", 32'(dif.out_valid), 32'd0);

    // Illegal encodings
    put(32'h00002063, 32'h200);
    tick();
    chk("br010_ill", 32'(dif.out_illegal), 32'd1);
    chk("br010_op", 32'(dif.out_alu_op), 32'(ALU_NOP));
    chk("br010_pc", dif.out_pc, 32'h200);
    chk("br010_cnt", 32'(cnt), 32'd1);
    put(32'h022081B3, 32'h204);
    tick();
    chk("mul_ill", 32'(dif.out_illegal), 32'd1);
    chk("mul_op", 32'(dif.out_alu_op), 32'(ALU_NOP));
    chk("mul_we", 32'(dif.out_r_we), 32'(REG_WD));
    chk("mul_cnt", 32'(cnt), 32'd2);
    put(32'h00000000, 32'h208);
    tick();
    chk("zero_ill", 32'(dif.out_illegal), 32'd1);
    chk("zero_cnt", 32'(cnt), 32'd3);
    put(32'h40101093, 32'h20C);
    tick();
    chk("slli_ill", 32'(dif.out_illegal), 32'd1);
    chk("slli_cnt", 32'(cnt), 32'd4);

    // Legal SRAI, SUB, JAL, BEQ
    put(32'h40105093, 32'h210);
    tick();
    chk("srai_op", 32'(dif.out_alu_op), 32'(ALU_SRA));
    chk("srai_ill", 32'(dif.out_illegal), 32'd0);
    put(32'h402081B3, 32'h214);
    tick();
    chk("sub_op", 32'(dif.out_alu_op), 32'(ALU_SUB));
    chk("sub_rs2", 32'(dif.out_rs2), 32'd2);
    put(32'hFFDFF0EF, 32'h240);
    tick();
    chk("jal_imm", dif.out_imm, 32'hFFFFFFFC);
    chk("jal_op", 32'(dif.out_alu_op), 32'(ALU_JAL));
    chk("jal_wb", 32'(dif.out_wb_from), 32'(WB_PC));
    chk("jal_we", 32'(dif.out_r_we), 32'(REG_WE));
    put(32'h00208463, 32'h244);
    tick();
    chk("beq_imm", dif.out_imm, 32'd8);
    chk("beq_op", 32'(dif.out_alu_op), 32'(ALU_BEQ));
    chk("beq_wb", 32'(dif.out_wb_from), 32'(WB_NONE));
    chk("beq_cnt", 32'(cnt), 32'd4);
    dif.in_valid = 1'b0;
    tick();

    // Flush in state TWO with a simultaneous illegal arrival
    dif.out_ready = 1'b0;
    put(32'h00100093, 32'h300);
    tick();
    put(32'h00200113, 32'h304);
    tick();
    chk("fl_two_ready", 32'(dif.in_ready), 32'd0);
    put(32'h00000000, 32'h308);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dif.in_valid = 1'b0;
    chk("fl_valid", 32'(dif.out_valid), 32'd0);
    chk("fl_ready", 32'(dif.in_ready), 32'd1);
    chk("fl_cnt", 32'(cnt), 32'd4);
    dif.out_ready = 1'b1;
    put(32'h00300193, 32'h30C);
    tick();
    chk("fl_next_pc", dif.out_pc, 32'h30C);
    chk("fl_next_valid", 32'(dif.out_valid), 32'd1);
    dif.in_valid = 1'b0;
    tick();
    chk("fl_drain", 32'(dif.out_valid), 32'd0);

    // Asynchronous reset mid-stream in state TWO
    dif.out_ready = 1'b0;
    put(32'h00100093, 32'h400);
    tick();
    put(32'h00200113, 32'h404);
    tick();
    chk("rs_two_ready", 32'(dif.in_ready), 32'd0);
    dif.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rs_valid", 32'(dif.out_valid), 32'd0);
    chk("rs_cnt", 32'(cnt), 32'd0);
    chk("rs_ready", 32'(dif.in_ready), 32'd1);
    reset = 1'b0;
    tick();

    // RV32M enabled instance and counter saturation
    dif_m.out_ready = 1'b1;
    put_m(32'h022081B3, 32'h500);
    tick();
    chk("m_mul_op", 32'(dif_m.out_alu_op), 32'(ALU_MUL));
    chk("m_mul_ill", 32'(dif_m.out_illegal), 32'd0);
    chk("m_mul_in2", 32'(dif_m.out_alu_in2), 32'(ALU_INPUT_REG));
    put_m(32'h0220B1B3, 32'h504);
    tick();
    chk("m_mulhu_op", 32'(dif_m.out_alu_op), 32'(ALU_MULHU));
    put_m(32'h0220F1B3, 32'h508);
    tick();
    chk("m_remu_op", 32'(dif_m.out_alu_op), 32'(ALU_REMU));
    put_m(32'h00000000, 32'h50C);
    tick();
    chk("m_cnt1", 32'(cnt_m), 32'd1);
    tick();
    chk("m_cnt2", 32'(cnt_m), 32'd2);
    tick();
    chk("m_cnt3", 32'(cnt_m), 32'd3);
    tick();
    chk("m_cnt_sat", 32'(cnt_m), 32'd3);
    chk("m_ill", 32'(dif_m.out_illegal), 32'd1);
    dif_m.in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction-decode pipeline stage for the rv32i core; sits between fetch and execute.
- Decodes RV32I, plus RV32M when enabled, into the rv32i package control fields.
- Flags illegal encodings and provides a 2-entry skid buffer so fetch and execute are decoupled without combinational ready paths.
- Supports pipeline flush on redirect and keeps a saturating illegal-instruction counter.

Parameters:
- XLEN, 32: datapath width of pc and imm; only 32 is supported.
- ENABLE_M, 0: 1 decodes OP with funct7=0000001 as MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (new alu_op_e values ALU_MUL..ALU_REMU, in funct3 order); 0 makes those encodings illegal.
- CNT_W, 16: width of the illegal-instruction counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all held and incoming instructions this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; registered (depends only on state).
- in_instr  in  32  instruction word (rv32i_inst_u).
- in_pc  in  XLEN  pc of in_instr.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  XLEN  pc of the bundle.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  XLEN  sign-extended immediate.
- out_alu_op  out  alu_op_e  ALU operation.
- out_alu_in1, out_alu_in2  out  alu_input_type_e  ALU operand sources.
- out_wb_from  out  wb_from_e  writeback source.
- out_r_we  out  reg_we_e  register write enable.
- out_mem_op  out  mem_op_e  memory operation.
- out_funct3  out  3  memory access width / sign for load-store.
- out_illegal  out  1  bundle is an illegal instruction.
- illegal_cnt  out  CNT_W  count of illegal instructions accepted.

Behaviour:
- Reset (async, immediate):
  - State EMPTY; out_valid=0, in_ready=1, illegal_cnt=0.
  - All bundle fields take NOP defaults: indices 0, imm 0, pc 0, funct3 0, ALU_NOP, ALU_INPUT_NONE, WB_NONE, REG_WD, MEM_LOAD, illegal 0.
- Handshakes:
  - Accept occurs when in_valid & in_ready.
  - Transfer occurs when out_valid & out_ready.
  - Latency accept -> out_valid is 1 cycle; throughput is 1 instruction/cycle while out_ready=1.
- States: EMPTY (no entry), ONE (output register full), TWO (output and skid registers full).
  - in_ready=1 in EMPTY and ONE, 0 in TWO; out_valid=1 in ONE and TWO.
  - EMPTY + accept -> ONE.
  - ONE: accept & transfer -> ONE (new bundle); accept only -> TWO (new bundle into skid); transfer only -> EMPTY.
  - TWO: transfer -> ONE; skid moves to the output register.
  - Order is strictly preserved; no bundle is lost or duplicated.
- flush has priority over all other events.
  - Next state is EMPTY; an in_valid in the same cycle is dropped.
  - The counter is not incremented for dropped instructions.
  - Bundle registers are not required to clear; out_valid=0 is sufficient.
- Decode is performed combinationally on in_instr and registered on accept; the skid holds already-decoded bundles.
  - LUI: in1=IMM, in2=NONE, ALU_ADD, WB_ALU, imm={instr[31:12],12'b0}.
  - AUIPC: in1=PC, in2=IMM, ALU_ADD, WB_ALU.
  - JAL/JALR: ALU_JAL/ALU_JALR, WB_PC, REG_WE; J/I immediates sign-extended, bit 0 zero for J.
  - BRANCH: REG_WD, WB_NONE, B immediate.
  - LOAD: WB_MEM, REG_WE.
  - STORE: MEM_STORE, REG_WD, WB_NONE, S immediate.
  - OP-IMM/OP: standard mapping; SRAI/SRA/SUB selected by funct7=0100000.
  - FENCE/SYSTEM: NOP bundle, not illegal.
  - out_funct3 = instr[14:12] for all opcodes.
  - If rd==0, out_r_we is forced to REG_WD.
- Illegal encodings:
  - instr[1:0]!=2'b11; unknown opcode.
  - BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3 >=011.
  - JALR funct3!=000.
  - SLLI with imm[11:5]!=0; SRLI/SRAI with imm[11:5] not 0000000/0100000.
  - OP funct7 not 0000000, not 0100000 (only for funct3 000/101), and not 0000001 (only when ENABLE_M=1).
- An illegal bundle carries the NOP defaults with out_illegal=1 and its pc preserved.
- illegal_cnt increments on accept of an illegal instruction and saturates at all-ones (no wrap).

Test Plan:
- ADDI x1,x0,5 (0x00500093) with out_ready=1 -> next cycle: out_valid=1, rd=1, rs1=0, imm=5, ALU_ADD, in2=IMM, REG_WE, illegal=0.
- LUI x1,0x12345 (0x123450B7), then SW x2,8(x1) (0x0020A423) back-to-back -> imm=0x12345000 then imm=8, MEM_STORE, REG_WD; one bundle per cycle.
- Hold out_ready=0 and offer 3 instructions -> in_ready=0 after the 2nd accept; the 3rd is held; releasing out_ready delivers the bundles in order with no loss.
- 0x00002063 (BRANCH funct3 010), then 0x022081B3 (MUL) with ENABLE_M=0 -> both illegal=1, ALU_NOP, illegal_cnt=2. With ENABLE_M=1, MUL gives ALU_MUL and illegal=0.
- In state TWO, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1; the flushed and incoming instructions never appear.
- Assert reset mid-stream in state TWO -> out_valid=0 and illegal_cnt=0 immediately, in_ready=1.
